// File: rtl/m_ifetch_pkg.sv
// m_ifetch_pkg: shared constants and types for the instruction fetch stage.
//   XLEN        - datapath width
//   ILEN_BYTES  - sequential PC step
//   NOP_INSN    - canonical RISC-V NOP (addi x0,x0,0)
//   fetch_entry_t - {pc, ir} pair held in the fetch queue
package m_ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] ILEN_BYTES = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSN   = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  // Word-align a fetch address (low two bits are ignored).
  function automatic logic [XLEN-1:0] f_align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/m_fifo.sv
// m_fifo: synchronous FIFO with flush, asynchronous active-high reset.
//   i_clk / i_rst       clock, async reset
//   i_flush             empties the FIFO; wins over push/pop in the same cycle
//   i_push / i_data     write port
//   i_pop               read port (head advances)
//   o_data              current head entry (stale contents when empty)
//   o_empty / o_count   occupancy
module m_fifo #(
  parameter int             W       = 64,
  parameter int             DEPTH   = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_data,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/m_ifetch.sv
// m_ifetch: instruction fetch stage. Owns the PC, drives a 1-cycle-latency
// synchronous instruction memory, buffers responses in a DEPTH-entry queue
// and hands {pc, ir} to decode over valid/ready.
//   w_clk, w_rst                    clock, async active-high reset
//   w_imem_req/addr, w_imem_data    instruction memory port
//   w_redirect, w_redirect_pc       flush and restart fetch
//   w_valid, w_ready, w_ir, w_pc    decode handshake
module m_ifetch
  import m_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic        w_imem_req,
  output logic [31:0] w_imem_addr,
  input  logic [31:0] w_imem_data,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_ir,
  output logic [31:0] w_pc
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tag;
  logic            r_inflight;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  fetch_entry_t    w_head;
  fetch_entry_t    w_in;

  assign w_valid = ~w_empty;
  assign w_pop   = w_valid & w_ready;

  // Projected occupancy after this cycle's pop, counting the read in flight.
  // A pop always has count >= 1, so this cannot underflow.
  assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue = ~w_rst & (w_redirect | (w_occ < (CW+1)'(DEPTH)));

  assign w_imem_req  = w_issue;
  assign w_imem_addr = w_redirect ? f_align(w_redirect_pc) : r_pc;

  // A response racing a redirect belongs to the old stream: drop it.
  assign w_push = r_inflight & ~w_redirect;
  assign w_in   = '{pc: r_tag, ir: w_imem_data};

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_pc       <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc  <= w_imem_addr + ILEN_BYTES;
        r_tag <= w_imem_addr;
      end
    end
  end

  m_fifo #(
    .W       ($bits(fetch_entry_t)),
    .DEPTH   (DEPTH),
    .RST_VAL ({32'h0, NOP_INSN})
  ) u_fifo (
    .i_clk   (w_clk),
    .i_rst   (w_rst),
    .i_flush (w_redirect),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_pc = w_head.pc;
  assign w_ir = w_head.ir;

endmodule

// File: tb/tb_m_ifetch.sv
module tb_m_ifetch;

  logic        w_clk = 1'b0;
  logic        w_rst;

  logic        req1, redir1, valid1, ready1;
  logic [31:0] addr1, data1, rpc1, ir1, pc1;
  logic        req2, valid2;
  logic [31:0] addr2, data2, ir2, pc2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 w_clk = ~w_clk;

  m_ifetch #(.RESET_PC(32'h0), .DEPTH(2)) dut1 (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_imem_req(req1), .w_imem_addr(addr1), .w_imem_data(data1),
    .w_redirect(redir1), .w_redirect_pc(rpc1),
    .w_valid(valid1), .w_ready(ready1), .w_ir(ir1), .w_pc(pc1)
  );

  m_ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_imem_req(req2), .w_imem_addr(addr2), .w_imem_data(data2),
    .w_redirect(1'b0), .w_redirect_pc(32'h0),
    .w_valid(valid2), .w_ready(1'b1), .w_ir(ir2), .w_pc(pc2)
  );

  function automatic logic [31:0] insn_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0010_8093;
      32'h4:   return 32'h0020_8113;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Synchronous-read instruction memories, one-cycle latency.
  always @(posedge w_clk) if (req1) data1 <= insn_at(addr1);
  always @(posedge w_clk) if (req2) data2 <= insn_at(addr2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge w_clk);
    #1;
  endtask

  task automatic out1(input string tag, input logic [31:0] epc);
    chk({tag, " valid"}, {31'b0, valid1}, 32'd1);
    chk({tag, " pc"}, pc1, epc);
    chk({tag, " ir"}, ir1, insn_at(epc));
  endtask

  initial begin
    w_rst  = 1'b1;
    ready1 = 1'b1;
    redir1 = 1'b0;
    rpc1   = 32'h0;
    #12;
    chk("rst valid", {31'b0, valid1}, 32'd0);
    chk("rst req",   {31'b0, req1},   32'd0);
    chk("rst pc",    pc1, 32'h0);
    chk("rst ir",    ir1, 32'h0000_0013);

    // Basic stream and wrap-around on the second instance.
    w_rst = 1'b0;
    #1;
    chk("c0 req",   {31'b0, req1}, 32'd1);
    chk("c0 addr",  addr1, 32'h0);
    chk("c0 addr2", addr2, 32'hFFFF_FFF8);
    tick;
    chk("c1 valid", {31'b0, valid1}, 32'd0);
    tick;
    out1("c2", 32'h0);
    chk("wrap0", pc2, 32'hFFFF_FFF8);
    tick;
    out1("c3", 32'h4);
    chk("wrap1", pc2, 32'hFFFF_FFFC);
    tick;
    out1("c4", 32'h8);
    chk("wrap2 pc", pc2, 32'h0);
    chk("wrap2 ir", ir2, 32'h0010_8093);
    tick;
    out1("c5", 32'hC);
    chk("wrap3", pc2, 32'h4);

    // Half-cycle reset pulse mid-stream.
    w_rst = 1'b1;
    #1;
    chk("arst valid", {31'b0, valid1}, 32'd0);
    chk("arst req",   {31'b0, req1},   32'd0);
    chk("arst ir",    ir1, 32'h0000_0013);
    #3;
    w_rst = 1'b0;
    #1;
    chk("rs c0 addr", addr1, 32'h0);
    tick;
    chk("rs c1 valid", {31'b0, valid1}, 32'd0);
    tick;
    out1("rs c2", 32'h0);

    // Backpressure from cycle 2.
    ready1 = 1'b0;
    #1;
    chk("bp req a", {31'b0, req1}, 32'd0);
    tick;
    chk("bp req b", {31'b0, req1}, 32'd0);
    out1("bp hold", 32'h0);
    tick;
    chk("bp count", {30'b0, dut1.w_count}, 32'd2);
    chk("bp req c", {31'b0, req1}, 32'd0);
    ready1 = 1'b1;
    #1;
    chk("bp resume req",  {31'b0, req1}, 32'd1);
    chk("bp resume addr", addr1, 32'h8);
    tick;
    out1("bp d1", 32'h4);
    tick;
    out1("bp d2", 32'h8);
    tick;
    out1("bp d3", 32'hC);

    // Redirect with a full queue.
    ready1 = 1'b0;
    tick;
    redir1 = 1'b1;
    rpc1   = 32'h0000_0103;
    #1;
    chk("rd req",  {31'b0, req1}, 32'd1);
    chk("rd addr", addr1, 32'h100);
    tick;
    redir1 = 1'b0;
    chk("rd n+1 valid", {31'b0, valid1}, 32'd0);
    tick;
    out1("rd n+2", 32'h100);
    ready1 = 1'b1;
    tick;
    out1("rd n+3", 32'h104);
    tick;
    out1("rd n+4", 32'h108);

    // Redirect coinciding with a pop, with a read in flight.
    redir1 = 1'b1;
    rpc1   = 32'h0000_0202;
    #1;
    chk("rp addr", addr1, 32'h200);
    tick;
    redir1 = 1'b0;
    chk("rp n+1 valid", {31'b0, valid1}, 32'd0);
    tick;
    out1("rp n+2", 32'h200);
    tick;
    out1("rp n+3", 32'h204);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
